// File: rtl/bloco_controle_horner.sv
// bloco_controle_horner
// Control FSM for a Horner-style polynomial datapath:
//   acc = c[DEGREE]; for i = DEGREE-1 downto 0: acc = acc*X + c[i]; S = acc.
// The multiplier may take MUL_LAT cycles; the accumulator is loaded only on
// the final multiply cycle.
//
// Ports:
//   clk       rising-edge clock
//   RST       synchronous active-high reset (priority over ABORT/START)
//   START     level run request, sampled only in IDLE and DONE
//   ABORT     returns a running sequence to IDLE without storing a result
//   LX/LH/LS  single-cycle load strobes for the X, H (accumulator), S registers
//   H         accumulator source: 1 = coefficient bus, 0 = ALU result
//   M0/M1     ALU operand selects: 00 zero, 01 X, 10 H, 11 coefficient
//   M2        ALU operation: 00 pass A, 01 add, 10 sub, 11 mul
//   COEF_IDX  coefficient index presented to the coefficient store
//   busy      high from LOAD_X through STORE
//   finished  high in DONE
module bloco_controle_horner #(
    parameter int DEGREE  = 2,
    parameter int MUL_LAT = 1,
    parameter int CW      = (DEGREE > 0) ? $clog2(DEGREE + 1) : 1
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          START,
    input  logic          ABORT,
    output logic          LX,
    output logic          LH,
    output logic          LS,
    output logic          H,
    output logic [1:0]    M0,
    output logic [1:0]    M1,
    output logic [1:0]    M2,
    output logic [CW-1:0] COEF_IDX,
    output logic          busy,
    output logic          finished
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_X = 3'd1,
        S_INIT   = 3'd2,
        S_MUL    = 3'd3,
        S_ADD    = 3'd4,
        S_STORE  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam int WW = 4;
    localparam logic [CW-1:0] IDX_TOP    = CW'(DEGREE);
    localparam logic [CW-1:0] IDX_TOP_M1 = CW'((DEGREE > 0) ? DEGREE - 1 : 0);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MUL_LAT - 1);

    state_t        state, state_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic [CW-1:0] idx, idx_n;

    assign COEF_IDX = idx;

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= S_IDLE;
            wcnt  <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n  = state;
        wcnt_n   = wcnt;
        idx_n    = idx;
        LX       = 1'b0;
        LH       = 1'b0;
        LS       = 1'b0;
        H        = 1'b0;
        M0       = 2'b00;
        M1       = 2'b00;
        M2       = 2'b00;
        busy     = 1'b0;
        finished = 1'b0;

        case (state)
            S_IDLE: begin
                if (START) begin
                    state_n = S_LOAD_X;
                    idx_n   = IDX_TOP;
                end
            end
            S_LOAD_X: begin
                LX      = 1'b1;
                busy    = 1'b1;
                state_n = S_INIT;
            end
            S_INIT: begin
                LH   = 1'b1;
                H    = 1'b1;
                busy = 1'b1;
                if (DEGREE == 0) begin
                    state_n = S_STORE;
                end else begin
                    idx_n   = IDX_TOP_M1;
                    wcnt_n  = '0;
                    state_n = S_MUL;
                end
            end
            S_MUL: begin
                M0   = 2'b10;
                M1   = 2'b01;
                M2   = 2'b11;
                busy = 1'b1;
                // Product is only valid on the last wait cycle; load it once.
                if (wcnt == WAIT_LAST) begin
                    LH      = 1'b1;
                    state_n = S_ADD;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                end
            end
            S_ADD: begin
                M0   = 2'b10;
                M1   = 2'b11;
                M2   = 2'b01;
                LH   = 1'b1;
                busy = 1'b1;
                if (idx == '0) begin
                    state_n = S_STORE;
                end else begin
                    idx_n   = idx - 1'b1;
                    wcnt_n  = '0;
                    state_n = S_MUL;
                end
            end
            S_STORE: begin
                LS      = 1'b1;
                M0      = 2'b10;
                busy    = 1'b1;
                state_n = S_DONE;
            end
            S_DONE: begin
                finished = 1'b1;
                if (!START) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Abort only matters while a sequence is running.
        if (ABORT && busy) state_n = S_IDLE;
    end

endmodule

// File: tb/tb_bloco_controle_horner.sv
module tb_bloco_controle_horner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: DEGREE=2, MUL_LAT=1 (table-driven, abort, reset)
    logic st_a = 1'b0, ab_a = 1'b0;
    logic lx_a, lh_a, ls_a, h_a, busy_a, fin_a;
    logic [1:0] m0_a, m1_a, m2_a, idx_a;
    // DUT B: DEGREE=0
    logic st_b = 1'b0;
    logic lx_b, lh_b, ls_b, h_b, busy_b, fin_b;
    logic [1:0] m0_b, m1_b, m2_b;
    logic [0:0] idx_b;
    // DUT C: DEGREE=3, MUL_LAT=3
    logic st_c = 1'b0;
    logic lx_c, lh_c, ls_c, h_c, busy_c, fin_c;
    logic [1:0] m0_c, m1_c, m2_c, idx_c;

    bloco_controle_horner #(.DEGREE(2), .MUL_LAT(1)) dut_a (
        .clk(clk), .RST(rst), .START(st_a), .ABORT(ab_a),
        .LX(lx_a), .LH(lh_a), .LS(ls_a), .H(h_a),
        .M0(m0_a), .M1(m1_a), .M2(m2_a), .COEF_IDX(idx_a),
        .busy(busy_a), .finished(fin_a));

    bloco_controle_horner #(.DEGREE(0), .MUL_LAT(1)) dut_b (
        .clk(clk), .RST(rst), .START(st_b), .ABORT(1'b0),
        .LX(lx_b), .LH(lh_b), .LS(ls_b), .H(h_b),
        .M0(m0_b), .M1(m1_b), .M2(m2_b), .COEF_IDX(idx_b),
        .busy(busy_b), .finished(fin_b));

    bloco_controle_horner #(.DEGREE(3), .MUL_LAT(3)) dut_c (
        .clk(clk), .RST(rst), .START(st_c), .ABORT(1'b0),
        .LX(lx_c), .LH(lh_c), .LS(ls_c), .H(h_c),
        .M0(m0_c), .M1(m1_c), .M2(m2_c), .COEF_IDX(idx_c),
        .busy(busy_c), .finished(fin_c));

    // ---------------- datapath models ----------------
    function automatic int sel(input logic [1:0] m, input int x, input int h, input int c);
        case (m)
            2'b00:   return 0;
            2'b01:   return x;
            2'b10:   return h;
            default: return c;
        endcase
    endfunction

    function automatic int alu(input logic [1:0] op, input int a, input int b);
        case (op)
            2'b00:   return a;
            2'b01:   return a + b;
            2'b10:   return a - b;
            default: return a * b;
        endcase
    endfunction

    int cf_a [0:3] = '{7, 5, 2, 0};   // c[0..2]; X = 3 -> S = 40
    int cf_b [0:1] = '{9, 0};         // c[0]       -> S = 9
    int cf_c [0:3] = '{4, 3, 2, 1};   // c[0..3]; X = 2 -> S = 26
    int xa = 0, ha = 0, sa = 0, ls_cnt_a = 0;
    int xb = 0, hb = 0, sb = 0;
    int xc = 0, hc = 0, sc = 0;

    always @(posedge clk) begin
        if (lx_a) xa <= 3;
        if (lh_a) ha <= h_a ? cf_a[idx_a]
                            : alu(m2_a, sel(m0_a, xa, ha, cf_a[idx_a]), sel(m1_a, xa, ha, cf_a[idx_a]));
        if (ls_a) begin
            sa       <= alu(m2_a, sel(m0_a, xa, ha, cf_a[idx_a]), sel(m1_a, xa, ha, cf_a[idx_a]));
            ls_cnt_a <= ls_cnt_a + 1;
        end
    end

    always @(posedge clk) begin
        if (lx_b) xb <= 5;
        if (lh_b) hb <= h_b ? cf_b[idx_b]
                            : alu(m2_b, sel(m0_b, xb, hb, cf_b[idx_b]), sel(m1_b, xb, hb, cf_b[idx_b]));
        if (ls_b) sb <= alu(m2_b, sel(m0_b, xb, hb, cf_b[idx_b]), sel(m1_b, xb, hb, cf_b[idx_b]));
    end

    always @(posedge clk) begin
        if (lx_c) xc <= 2;
        if (lh_c) hc <= h_c ? cf_c[idx_c]
                            : alu(m2_c, sel(m0_c, xc, hc, cf_c[idx_c]), sel(m1_c, xc, hc, cf_c[idx_c]));
        if (ls_c) sc <= alu(m2_c, sel(m0_c, xc, hc, cf_c[idx_c]), sel(m1_c, xc, hc, cf_c[idx_c]));
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // LX/LH/LS never overlap, on any instance, once out of reset.
    logic mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("onehot_a", int'(lx_a) + int'(lh_a) + int'(ls_a) > 1, 0);
            chk("onehot_b", int'(lx_b) + int'(lh_b) + int'(ls_b) > 1, 0);
            chk("onehot_c", int'(lx_c) + int'(lh_c) + int'(ls_c) > 1, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected output patterns {LX,LH,LS,H, M0,M1,M2, busy,finished}
    localparam logic [11:0] O_IDLE  = 12'b0000_00_00_00_0_0;
    localparam logic [11:0] O_LOADX = 12'b1000_00_00_00_1_0;
    localparam logic [11:0] O_INIT  = 12'b0101_00_00_00_1_0;
    localparam logic [11:0] O_MULL  = 12'b0100_10_01_11_1_0;
    localparam logic [11:0] O_ADD   = 12'b0100_10_11_01_1_0;
    localparam logic [11:0] O_STORE = 12'b0010_10_00_00_1_0;
    localparam logic [11:0] O_DONE  = 12'b0000_00_00_00_0_1;

    typedef struct {
        logic        st;
        logic        ab;
        logic [11:0] o;
        logic [1:0]  idx;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic ab, input logic [11:0] o, input logic [1:0] idx);
        vec_t v;
        v.st = st; v.ab = ab; v.o = o; v.idx = idx;
        return v;
    endfunction

    function automatic int out_a();
        return int'({lx_a, lh_a, ls_a, h_a, m0_a, m1_a, m2_a, busy_a, fin_a, idx_a});
    endfunction

    initial begin
        int n;
        int first_lx, first_lh, first_ls, first_fin, h_at_lh;
        int mul_cyc, mul_lh, mul_run;

        // run 1: START held, DONE held, ABORT ignored in DONE
        tbl.push_back(mk(1, 0, O_IDLE,  0));
        tbl.push_back(mk(1, 0, O_LOADX, 2));
        tbl.push_back(mk(1, 0, O_INIT,  2));
        tbl.push_back(mk(1, 0, O_MULL,  1));
        tbl.push_back(mk(1, 0, O_ADD,   1));
        tbl.push_back(mk(1, 0, O_MULL,  0));
        tbl.push_back(mk(1, 0, O_ADD,   0));
        tbl.push_back(mk(1, 0, O_STORE, 0));
        tbl.push_back(mk(1, 0, O_DONE,  0));
        tbl.push_back(mk(1, 1, O_DONE,  0));
        tbl.push_back(mk(0, 0, O_DONE,  0));
        tbl.push_back(mk(0, 0, O_IDLE,  0));
        tbl.push_back(mk(1, 0, O_IDLE,  0));
        // run 2: START toggling while busy has no effect; ABORT ignored in IDLE
        tbl.push_back(mk(0, 0, O_LOADX, 2));
        tbl.push_back(mk(1, 0, O_INIT,  2));
        tbl.push_back(mk(0, 0, O_MULL,  1));
        tbl.push_back(mk(1, 0, O_ADD,   1));
        tbl.push_back(mk(0, 0, O_MULL,  0));
        tbl.push_back(mk(1, 0, O_ADD,   0));
        tbl.push_back(mk(1, 0, O_STORE, 0));
        tbl.push_back(mk(0, 0, O_DONE,  0));
        tbl.push_back(mk(0, 1, O_IDLE,  0));
        tbl.push_back(mk(1, 0, O_IDLE,  0));
        // run 3: ABORT during cycle 5 (second MUL)
        tbl.push_back(mk(0, 0, O_LOADX, 2));
        tbl.push_back(mk(0, 0, O_INIT,  2));
        tbl.push_back(mk(0, 0, O_MULL,  1));
        tbl.push_back(mk(0, 0, O_ADD,   1));
        tbl.push_back(mk(0, 1, O_MULL,  0));
        tbl.push_back(mk(0, 0, O_IDLE,  0));
        tbl.push_back(mk(0, 0, O_IDLE,  0));

        // reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_a", out_a(), int'({O_IDLE, 2'd0}));
        chk("reset_b", int'({lx_b, lh_b, ls_b, busy_b, fin_b}), 0);
        chk("reset_c", int'({lx_c, lh_c, ls_c, busy_c, fin_c, idx_c}), 0);
        mon_en = 1'b1;
        @(negedge clk);

        // table
        for (int i = 0; i < tbl.size(); i++) begin
            st_a = tbl[i].st;
            ab_a = tbl[i].ab;
            chk($sformatf("row%0d", i), out_a(), int'({tbl[i].o, tbl[i].idx}));
            if (i == 12) chk("s_run1", sa, 40);
            @(negedge clk);
        end
        st_a = 1'b0;
        ab_a = 1'b0;
        chk("s_final", sa, 40);
        chk("ls_count", ls_cnt_a, 2);

        // reset during MUL, then a fresh run at nominal latency
        @(negedge clk);
        st_a = 1'b1;
        @(negedge clk);
        st_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_mul", int'(m2_a), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_clear", out_a(), int'({O_IDLE, 2'd0}));
        st_a = 1'b1;
        first_fin = -1;
        for (n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (fin_a) begin
                first_fin = n;
                break;
            end
        end
        chk("rst_rerun_lat", first_fin, 8);
        st_a = 1'b0;
        @(negedge clk);
        chk("rst_rerun_idle", out_a(), int'({O_IDLE, 2'd0}));

        // DEGREE = 0
        first_lx = -1; first_lh = -1; first_ls = -1; first_fin = -1; h_at_lh = -1;
        st_b = 1'b1;
        for (n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) st_b = 1'b0;
            if (lx_b && first_lx < 0) first_lx = n;
            if (lh_b && first_lh < 0) begin first_lh = n; h_at_lh = int'(h_b); end
            if (ls_b && first_ls < 0) first_ls = n;
            if (fin_b) begin first_fin = n; break; end
        end
        chk("d0_lx_cycle", first_lx, 1);
        chk("d0_lh_cycle", first_lh, 2);
        chk("d0_h_sel", h_at_lh, 1);
        chk("d0_ls_cycle", first_ls, 3);
        chk("d0_fin_cycle", first_fin, 4);
        chk("d0_idx", int'(idx_b), 0);
        chk("d0_s", sb, 9);

        // DEGREE = 3, MUL_LAT = 3
        first_fin = -1; mul_cyc = 0; mul_lh = 0; mul_run = 0;
        st_c = 1'b1;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) st_c = 1'b0;
            if (m2_c == 2'b11) begin
                mul_cyc++;
                mul_run++;
                if (lh_c) begin
                    mul_lh++;
                    chk($sformatf("d3_mul_len%0d", mul_lh), mul_run, 3);
                    mul_run = 0;
                end
            end
            if (fin_c) begin first_fin = n; break; end
        end
        chk("d3_fin_cycle", first_fin, 16);
        chk("d3_mul_cycles", mul_cyc, 9);
        chk("d3_mul_loads", mul_lh, 3);
        chk("d3_s", sc, 26);

        @(negedge clk);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
